// File: rtl/timer_device_if.sv
// Bus-side connection of the timer peripheral: select, write strobe, byte
// enables, word address and data, plus the returned read data and interrupt.
interface timer_device_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output sel, we, addr, be, wdata,
        input  rdata, irq
    );

    modport slave (
        input  sel, we, addr, be, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped programmable down-counter with prescaler, one-shot and
// auto-reload modes, and a maskable level interrupt for one HW_Int line.
module timer_device #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic          clk,
    input  logic          reset,
    timer_device_if.slave bus
);

    localparam int unsigned    PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t          state_q, state_d;
    logic            en_q;
    logic [1:0]      mode_q;
    logic            im_q;
    logic [31:0]     preset_q;
    logic [31:0]     count_q;
    logic [PW-1:0]   presc_q;
    logic            tick_q;
    logic            irq_pend_q;

    logic            wr_ctrl;
    logic            wr_preset;
    logic            auto_reload;
    logic            enter_load;
    logic            load;
    logic            dec;
    logic            expire;
    logic            int_exit;
    logic            set_pend;
    logic            ack;

    assign wr_ctrl     = bus.sel && bus.we && (bus.addr == ADDR_CTRL);
    assign wr_preset   = bus.sel && bus.we && (bus.addr == ADDR_PRESET);
    // MODE 1x behaves exactly like one-shot.
    assign auto_reload = (mode_q == 2'b01);

    // A write acknowledges the interrupt only while it is visible; a pending
    // but masked interrupt survives the write that unmasks it.
    assign ack = (wr_ctrl || wr_preset) && !auto_reload && im_q;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        dec      = 1'b0;
        expire   = 1'b0;
        int_exit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = (preset_q == 32'd0) ? S_INT : S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (tick_q) begin
                    if (count_q > 32'd1) begin
                        dec = 1'b1;
                    end else begin
                        expire  = 1'b1;
                        state_d = S_INT;
                    end
                end
            end
            S_INT: begin
                int_exit = 1'b1;
                state_d  = auto_reload ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);
    assign set_pend   = (state_d == S_INT) && (state_q != S_INT);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others; all state is cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;

            // The tick is the registered terminal count, so it lands one
            // cycle after the prescaler reaches PRESCALE-1.
            if (enter_load) begin
                presc_q <= '0;
                tick_q  <= 1'b0;
            end else begin
                tick_q <= (presc_q == PRESC_LAST);
                if (state_q == S_CNT && en_q) begin
                    presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
                end
            end

            if (load) begin
                count_q <= preset_q;
            end else if (dec) begin
                count_q <= count_q - 32'd1;
            end else if (expire) begin
                count_q <= '0;
            end

            // A software write to CTRL on the same edge overrides the
            // one-shot self-disable.
            if (int_exit && !auto_reload) en_q <= 1'b0;
            if (wr_ctrl && bus.be[0]) begin
                en_q   <= bus.wdata[0];
                mode_q <= bus.wdata[2:1];
                im_q   <= bus.wdata[3];
            end

            for (int i = 0; i < 4; i++) begin
                if (wr_preset && bus.be[i]) begin
                    preset_q[8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end

            if (set_pend) begin
                irq_pend_q <= 1'b1;
            end else if (int_exit && auto_reload) begin
                irq_pend_q <= 1'b0;
            end else if (ack) begin
                irq_pend_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        unique case (bus.addr)
            ADDR_CTRL:   bus.rdata = {28'd0, im_q, mode_q, en_q};
            ADDR_PRESET: bus.rdata = preset_q;
            ADDR_COUNT:  bus.rdata = count_q;
            default:     bus.rdata = '0;
        endcase
    end

    assign bus.irq = irq_pend_q & im_q;

endmodule
